// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generator with a single-cycle memory
// interface and a first-word fall-through prefetch buffer with redirect/hold.
module fetch_unit #(
   parameter int          ADDR_W   = 32,
   parameter int          INSTR_W  = 16,
   parameter int          DEPTH    = 4,
   parameter int unsigned RESET_PC = 32'd32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       redirect_i,
   input  logic [ADDR_W-1:0]          redirect_pc_i,
   input  logic                       hold_i,
   output logic                       imem_req_o,
   output logic [ADDR_W-1:0]          imem_addr_o,
   input  logic [INSTR_W-1:0]         imem_rdata_i,
   output logic                       instr_valid_o,
   output logic [INSTR_W-1:0]         instr_o,
   output logic [ADDR_W-1:0]          instr_pc_o,
   input  logic                       instr_ready_i,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count_o
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0]  pc_q,       pc_d;
   logic               inflight_q, inflight_d;
   logic [ADDR_W-1:0]  req_pc_q,   req_pc_d;
   logic [CNT_W-1:0]   count_q,    count_d;
   logic [PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
   logic [INSTR_W-1:0] buf_instr_q [DEPTH];
   logic [INSTR_W-1:0] buf_instr_d [DEPTH];
   logic [ADDR_W-1:0]  buf_pc_q    [DEPTH];
   logic [ADDR_W-1:0]  buf_pc_d    [DEPTH];

   logic               req_s;
   logic               push_s;
   logic               pop_s;
   logic [CNT_W:0]     credit_used_s;

   // Request/credit, push/pop decisions and externally visible outputs
   always_comb begin
      // Credit counts the word in flight so a returning word always has a slot.
      credit_used_s = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
      req_s         = rst & ~hold_i & ~redirect_i
                      & (credit_used_s < (CNT_W + 1)'(DEPTH));
      push_s        = inflight_q & ~redirect_i;
      pop_s         = (count_q != {CNT_W{1'b0}}) & instr_ready_i & ~redirect_i;

      imem_req_o    = req_s;
      imem_addr_o   = pc_q;
      instr_valid_o = (count_q != {CNT_W{1'b0}});
      instr_o       = buf_instr_q[rd_ptr_q];
      instr_pc_o    = buf_pc_q[rd_ptr_q];
      fifo_count_o  = count_q;
   end

   // Next-state for PC, in-flight tracking, pointers, occupancy and storage
   always_comb begin
      pc_d        = pc_q;
      inflight_d  = req_s;
      req_pc_d    = req_pc_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;

      if (req_s) begin
         req_pc_d = pc_q;
      end else begin
         req_pc_d = req_pc_q;
      end

      if (redirect_i) begin
         pc_d     = redirect_pc_i;
         count_d  = {CNT_W{1'b0}};
         wr_ptr_d = {PTR_W{1'b0}};
         rd_ptr_d = {PTR_W{1'b0}};
      end else begin
         if (req_s) begin
            pc_d = pc_q + ADDR_W'(1);
         end else begin
            pc_d = pc_q;
         end

         if (push_s) begin
            buf_instr_d[wr_ptr_q] = imem_rdata_i;
            buf_pc_d[wr_ptr_q]    = req_pc_q;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end

         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end

         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= ADDR_W'(RESET_PC);
         inflight_q <= 1'b0;
         req_pc_q   <= {ADDR_W{1'b0}};
         count_q    <= {CNT_W{1'b0}};
         wr_ptr_q   <= {PTR_W{1'b0}};
         rd_ptr_q   <= {PTR_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            buf_instr_q[i] <= {INSTR_W{1'b0}};
            buf_pc_q[i]    <= {ADDR_W{1'b0}};
         end
      end else begin
         pc_q        <= pc_d;
         inflight_q  <= inflight_d;
         req_pc_q    <= req_pc_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit: back-pressure, async reset,
// streaming, redirect, hold, address wrap and redirect-over-hold priority.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic        hold_i = 1'b0;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic [15:0] imem_rdata_i = 16'h0;
   logic        instr_valid_o;
   logic [15:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i = 1'b0;
   logic [2:0]  fifo_count_o;

   int n_vec = 0;
   int n_bad = 0;

   fetch_unit dut (
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .hold_i        (hold_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_rdata_i  (imem_rdata_i),
      .instr_valid_o (instr_valid_o),
      .instr_o       (instr_o),
      .instr_pc_o    (instr_pc_o),
      .instr_ready_i (instr_ready_i),
      .fifo_count_o  (fifo_count_o)
   );

   always #5 clk = ~clk;

   // Memory returns addr^0xAAAA the cycle after a request, junk otherwise
   always @(posedge clk) begin
      if (imem_req_o) imem_rdata_i <= imem_addr_o[15:0] ^ 16'hAAAA;
      else            imem_rdata_i <= 16'hDEAD;
   end

   typedef struct {
      logic        rdy;
      logic        hold;
      logic        redir;
      logic [31:0] rpc;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
      logic [2:0]  cnt;
   } vec_t;

   vec_t ph1[$];
   vec_t ph2[$];

   function automatic vec_t mk(logic rdy, logic hold, logic redir, logic [31:0] rpc,
                               logic req, logic [31:0] addr, logic valid,
                               logic [31:0] pc, logic [2:0] cnt);
      vec_t v;
      v.rdy = rdy; v.hold = hold; v.redir = redir; v.rpc = rpc;
      v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag, input int idx);
      instr_ready_i = v.rdy;
      hold_i        = v.hold;
      redirect_i    = v.redir;
      redirect_pc_i = v.rpc;
      #1;
      chk($sformatf("%s[%0d] req", tag, idx),   {31'h0, imem_req_o},    {31'h0, v.req});
      chk($sformatf("%s[%0d] addr", tag, idx),  imem_addr_o,            v.addr);
      chk($sformatf("%s[%0d] valid", tag, idx), {31'h0, instr_valid_o}, {31'h0, v.valid});
      chk($sformatf("%s[%0d] count", tag, idx), {29'h0, fifo_count_o},  {29'h0, v.cnt});
      if (v.valid) begin
         chk($sformatf("%s[%0d] pc", tag, idx),    instr_pc_o,       v.pc);
         chk($sformatf("%s[%0d] instr", tag, idx), {16'h0, instr_o}, {16'h0, v.pc[15:0] ^ 16'hAAAA});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Back-pressure from reset: fill to 4, drain in order, refill to full
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,32'h20,1'b0,32'h0, 3'd0));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,32'h21,1'b0,32'h0, 3'd0));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,32'h22,1'b1,32'h20,3'd1));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,32'h23,1'b1,32'h20,3'd2));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,32'h24,1'b1,32'h20,3'd3));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,32'h24,1'b1,32'h20,3'd4));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,32'h24,1'b1,32'h20,3'd4));
      ph1.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b0,32'h24,1'b1,32'h20,3'd4));
      ph1.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b1,32'h24,1'b1,32'h21,3'd3));
      ph1.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b1,32'h25,1'b1,32'h22,3'd2));
      ph1.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b1,32'h26,1'b1,32'h23,3'd2));
      ph1.push_back(mk(1'b1,1'b0,1'b0,32'h0, 1'b1,32'h27,1'b1,32'h24,3'd2));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b1,32'h28,1'b1,32'h25,3'd2));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,32'h29,1'b1,32'h25,3'd3));
      ph1.push_back(mk(1'b0,1'b0,1'b0,32'h0, 1'b0,32'h29,1'b1,32'h25,3'd4));

      // Stream, redirect with 3 buffered + 1 in flight, hold, wrap, redirect over hold
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h20,      1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h21,      1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h22,      1'b1,32'h20,      3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h23,      1'b1,32'h21,      3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h24,      1'b1,32'h22,      3'd1));
      ph2.push_back(mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h25,      1'b1,32'h23,      3'd1));
      ph2.push_back(mk(1'b0,1'b0,1'b0,32'h0,       1'b1,32'h26,      1'b1,32'h23,      3'd2));
      ph2.push_back(mk(1'b1,1'b0,1'b1,32'h100,     1'b0,32'h27,      1'b1,32'h23,      3'd3));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h100,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h101,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h102,     1'b1,32'h100,     3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h103,     1'b1,32'h101,     3'd1));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h104,     1'b1,32'h102,     3'd1));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h104,     1'b1,32'h103,     3'd1));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h104,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h104,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h104,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h104,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h105,     1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h106,     1'b1,32'h104,     3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b1,32'hFFFFFFFF,1'b0,32'h107,     1'b1,32'h105,     3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'hFFFFFFFF,1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h0,       1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h1,       1'b1,32'hFFFFFFFF,3'd1));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h2,       1'b1,32'h0,       3'd1));
      ph2.push_back(mk(1'b1,1'b1,1'b1,32'h40,      1'b0,32'h3,       1'b1,32'h1,       3'd1));
      ph2.push_back(mk(1'b1,1'b1,1'b0,32'h0,       1'b0,32'h40,      1'b0,32'h0,       3'd0));
      ph2.push_back(mk(1'b1,1'b0,1'b0,32'h0,       1'b1,32'h40,      1'b0,32'h0,       3'd0));

      // Reset state
      #1 rst = 1'b0;
      #1;
      chk("rst valid", {31'h0, instr_valid_o}, 32'h0);
      chk("rst req",   {31'h0, imem_req_o},    32'h0);
      chk("rst count", {29'h0, fifo_count_o},  32'h0);
      chk("rst addr",  imem_addr_o,            32'h20);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      foreach (ph1[i]) run_vec(ph1[i], "bp", i);

      // Async reset between edges with a full buffer
      #2 rst = 1'b0;
      #1;
      chk("async valid", {31'h0, instr_valid_o}, 32'h0);
      chk("async count", {29'h0, fifo_count_o},  32'h0);
      chk("async req",   {31'h0, imem_req_o},    32'h0);
      chk("async addr",  imem_addr_o,            32'h20);
      instr_ready_i = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      foreach (ph2[i]) run_vec(ph2[i], "run", i);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
